// File: rtl/tx_ltssm_os_generator.sv
// Builds per-lane TS1/TS2 ordered sets for the current LTSSM substate and streams them until done.
// Start->first valid 1 cycle; data held while txReady=0; finish 1 cycle after the last accepted set.
module tx_ltssm_os_generator #(
    parameter int         DEVICETYPE = 0,
    parameter logic [7:0] NFTS       = 8'h80
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [4:0]    substate,
    input  logic [2:0]    gen,
    input  logic [4:0]    numberOfDetectedLanes,
    input  logic [7:0]    linkNumber,
    input  logic [7:0]    rateId,
    input  logic          rxFinish,
    input  logic          txReady,
    output logic [2047:0] orderedSets,
    output logic          validOrderedSets,
    output logic          finish,
    output logic [10:0]   sentCount
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [7:0] COM     = 8'hBC;
    localparam logic [7:0] PAD     = 8'hF7;
    localparam logic [7:0] TS1_ID  = 8'h4A;
    localparam logic [7:0] TS2_ID  = 8'h45;
    localparam logic [7:0] TS1_SYN = 8'h1E;
    localparam logic [7:0] TS2_SYN = 8'h2D;

    logic [1:0]    state;
    logic [4:0]    subLatched;
    logic          rxLatch;
    logic [10:0]   countAfter;
    logic          exitSend;
    logic [2047:0] nextSets;
    logic          isTs2;
    logic [7:0]    byte0;
    logic [7:0]    byte1;
    logic [7:0]    byte2;
    logic [7:0]    fillByte;

    function automatic logic isSupported(input logic [4:0] s);
        return (s == 5'd1) || (s == 5'd2) || (s == 5'd3) ||
               (s == 5'd5) || (s == 5'd9) || (s == 5'd10);
    endfunction

    function automatic logic [10:0] minCount(input logic [4:0] s);
        case (s)
            5'd1:                minCount = 11'd1024;
            5'd2, 5'd5, 5'd10:   minCount = 11'd16;
            default:             minCount = 11'd1;
        endcase
    endfunction

    // Set contents depend only on start-time inputs, so they are built once and registered.
    always_comb begin
        nextSets = '0;
        isTs2    = (substate == 5'd2) || (substate == 5'd5) || (substate == 5'd10);
        fillByte = isTs2 ? TS2_ID : TS1_ID;
        byte0    = COM;
        byte1    = linkNumber;
        byte2    = 8'h00;
        if (gen >= 3'd3) begin
            byte0 = isTs2 ? TS2_SYN : TS1_SYN;
        end
        if (substate == 5'd3 && DEVICETYPE == 0) begin
            byte1 = PAD;
        end
        for (int i = 0; i < 16; i++) begin
            byte2 = (substate == 5'd3) ? PAD : 8'(i);
            if (i < int'(numberOfDetectedLanes)) begin
                nextSets[128*i +: 128] = {{10{fillByte}}, 8'h00, rateId, NFTS, byte2, byte1, byte0};
            end
        end
    end

    always_comb begin
        countAfter = sentCount;
        if (txReady && sentCount != 11'h7FF) begin
            countAfter = sentCount + 11'd1;
        end
        exitSend = (countAfter >= minCount(subLatched)) && (rxLatch || rxFinish);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            subLatched       <= 5'd0;
            rxLatch          <= 1'b0;
            sentCount        <= 11'd0;
            orderedSets      <= '0;
            validOrderedSets <= 1'b0;
            finish           <= 1'b0;
        end else begin
            finish <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sentCount <= 11'd0;
                        rxLatch   <= 1'b0;
                        if (isSupported(substate)) begin
                            subLatched       <= substate;
                            orderedSets      <= nextSets;
                            validOrderedSets <= 1'b1;
                            state            <= SEND;
                        end else begin
                            finish <= 1'b1;
                            state  <= DONE;
                        end
                    end
                end
                SEND: begin
                    sentCount <= countAfter;
                    if (rxFinish) begin
                        rxLatch <= 1'b1;
                    end
                    if (exitSend) begin
                        orderedSets      <= '0;
                        validOrderedSets <= 1'b0;
                        finish           <= 1'b1;
                        state            <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tx_ltssm_os_generator.sv
// Directed bench for tx_ltssm_os_generator; dut0 is an upstream port, dut1 a downstream port.
module tb_tx_ltssm_os_generator;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [4:0]    substate;
    logic [2:0]    gen;
    logic [4:0]    numberOfDetectedLanes;
    logic [7:0]    linkNumber;
    logic [7:0]    rateId;
    logic          rxFinish;
    logic          txReady;
    logic [2047:0] os0, os1;
    logic          vld0, vld1, fin0, fin1;
    logic [10:0]   cnt0, cnt1;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    tx_ltssm_os_generator #(.DEVICETYPE(0), .NFTS(8'h80)) dut0 (
        .clk(clk), .reset(reset), .start(start), .substate(substate), .gen(gen),
        .numberOfDetectedLanes(numberOfDetectedLanes), .linkNumber(linkNumber),
        .rateId(rateId), .rxFinish(rxFinish), .txReady(txReady),
        .orderedSets(os0), .validOrderedSets(vld0), .finish(fin0), .sentCount(cnt0)
    );

    tx_ltssm_os_generator #(.DEVICETYPE(1), .NFTS(8'h80)) dut1 (
        .clk(clk), .reset(reset), .start(start), .substate(substate), .gen(gen),
        .numberOfDetectedLanes(numberOfDetectedLanes), .linkNumber(linkNumber),
        .rateId(rateId), .rxFinish(rxFinish), .txReady(txReady),
        .orderedSets(os1), .validOrderedSets(vld1), .finish(fin1), .sentCount(cnt1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        compared++;
        if (os0 !== '0 || vld0 !== 1'b0 || fin0 !== 1'b0 || cnt0 !== 11'd0) begin
            mismatched++;
            $display("FAIL reset_dut0 got vld=%b fin=%b cnt=%0d osZero=%b want 0 0 0 1", vld0, fin0, cnt0, os0 == '0);
        end
        compared++;
        if (os1 !== '0 || vld1 !== 1'b0 || fin1 !== 1'b0 || cnt1 !== 11'd0) begin
            mismatched++;
            $display("FAIL reset_dut1 got vld=%b fin=%b cnt=%0d osZero=%b want 0 0 0 1", vld1, fin1, cnt1, os1 == '0);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_ts2_gen1();
        logic [127:0]  expLane;
        logic [2047:0] snap;
        int            validCycles;
        int            finishTick;
        logic          stable;
        expLane = {{10{8'h45}}, 8'h00, 8'h02, 8'h80, 8'h02, 8'h00, 8'hBC};
        gen = 3'd1; substate = 5'd10; numberOfDetectedLanes = 5'd4;
        linkNumber = 8'h00; rateId = 8'h02; txReady = 1'b1; rxFinish = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        snap = os0;
        compared++;
        if (os0[256 +: 128] !== expLane) begin
            mismatched++;
            $display("FAIL ts2_lane2 got %h want %h", os0[256 +: 128], expLane);
        end
        compared++;
        if (os0[2047:512] !== '0) begin
            mismatched++;
            $display("FAIL ts2_inactive_lanes got nonzero want zero");
        end
        validCycles = 0; finishTick = -1; stable = 1'b1;
        for (int t = 1; t <= 40; t++) begin
            if (vld0) begin
                validCycles++;
                if (os0 !== snap) stable = 1'b0;
            end
            if (fin0) begin
                finishTick = t;
                break;
            end
            rxFinish = (t == 2);
            tick();
        end
        rxFinish = 1'b0;
        compared++;
        if (validCycles != 16 || finishTick != 17) begin
            mismatched++;
            $display("FAIL ts2_count got valid=%0d finishTick=%0d want 16 17", validCycles, finishTick);
        end
        compared++;
        if (cnt0 !== 11'd16 || vld0 !== 1'b0 || !stable) begin
            mismatched++;
            $display("FAIL ts2_end got cnt=%0d vld=%b stable=%b want 16 0 1", cnt0, vld0, stable);
        end
        tick();
        compared++;
        if (fin0 !== 1'b0) begin
            mismatched++;
            $display("FAIL ts2_finish_width got %b want 0", fin0);
        end
    endtask

    task automatic test_polling_gen3();
        logic [127:0] expLane;
        int           validCycles;
        int           finishTick;
        expLane = {{10{8'h4A}}, 8'h00, 8'h04, 8'h80, 8'h00, 8'h07, 8'h1E};
        gen = 3'd3; substate = 5'd1; numberOfDetectedLanes = 5'd1;
        linkNumber = 8'h07; rateId = 8'h04; txReady = 1'b1; rxFinish = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        compared++;
        if (os0[127:0] !== expLane || os0[2047:128] !== '0) begin
            mismatched++;
            $display("FAIL gen3_lane0 got %h want %h (upper zero=%b)", os0[127:0], expLane, os0[2047:128] == '0);
        end
        validCycles = 0; finishTick = -1;
        for (int t = 1; t <= 1100; t++) begin
            if (vld0) validCycles++;
            if (fin0) begin
                finishTick = t;
                break;
            end
            rxFinish = (t == 1);
            tick();
        end
        rxFinish = 1'b0;
        compared++;
        if (validCycles != 1024 || finishTick != 1025 || cnt0 !== 11'd1024) begin
            mismatched++;
            $display("FAIL gen3_count got valid=%0d finishTick=%0d cnt=%0d want 1024 1025 1024", validCycles, finishTick, cnt0);
        end
        tick();
    endtask

    task automatic test_link_width();
        logic [127:0] exp0;
        logic [127:0] exp1;
        gen = 3'd2; substate = 5'd3; numberOfDetectedLanes = 5'd16;
        linkNumber = 8'h33; rateId = 8'h01; txReady = 1'b1; rxFinish = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            exp0 = {{10{8'h4A}}, 8'h00, 8'h01, 8'h80, 8'hF7, 8'hF7, 8'hBC};
            exp1 = {{10{8'h4A}}, 8'h00, 8'h01, 8'h80, 8'hF7, 8'h33, 8'hBC};
            compared++;
            if (os0[128*i +: 128] !== exp0) begin
                mismatched++;
                $display("FAIL lw_up_lane%0d got %h want %h", i, os0[128*i +: 128], exp0);
            end
            compared++;
            if (os1[128*i +: 128] !== exp1) begin
                mismatched++;
                $display("FAIL lw_down_lane%0d got %h want %h", i, os1[128*i +: 128], exp1);
            end
        end
        rxFinish = 1'b1;
        tick();
        rxFinish = 1'b0;
        compared++;
        if (fin0 !== 1'b1 || fin1 !== 1'b1 || cnt0 !== 11'd1) begin
            mismatched++;
            $display("FAIL lw_finish got fin0=%b fin1=%b cnt=%0d want 1 1 1", fin0, fin1, cnt0);
        end
        tick();
    endtask

    task automatic test_stall();
        logic [2047:0] snap;
        int            expCnt;
        logic          ok;
        gen = 3'd1; substate = 5'd9; numberOfDetectedLanes = 5'd2;
        linkNumber = 8'h05; rateId = 8'h01; txReady = 1'b0; rxFinish = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        snap = os0;
        compared++;
        if (cnt0 !== 11'd0 || vld0 !== 1'b1) begin
            mismatched++;
            $display("FAIL stall_begin got cnt=%0d vld=%b want 0 1", cnt0, vld0);
        end
        expCnt = 0; ok = 1'b1;
        for (int k = 0; k < 8; k++) begin
            txReady = (k % 2 == 0);
            tick();
            if (txReady) expCnt++;
            compared++;
            if (cnt0 !== 11'(expCnt) || vld0 !== 1'b1 || fin0 !== 1'b0 || os0 !== snap) begin
                mismatched++;
                $display("FAIL stall_step%0d got cnt=%0d vld=%b fin=%b same=%b want %0d 1 0 1",
                         k, cnt0, vld0, fin0, os0 == snap, expCnt);
            end
        end
        txReady = 1'b0;
        rxFinish = 1'b1;
        tick();
        rxFinish = 1'b0;
        compared++;
        if (fin0 !== 1'b1 || vld0 !== 1'b0 || cnt0 !== 11'd4) begin
            mismatched++;
            $display("FAIL stall_finish got fin=%b vld=%b cnt=%0d want 1 0 4", fin0, vld0, cnt0);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        gen = 3'd1; substate = 5'd20; numberOfDetectedLanes = 5'd4;
        txReady = 1'b1; rxFinish = 1'b0;
        start = 1'b1;
        tick();
        compared++;
        if (fin0 !== 1'b1 || vld0 !== 1'b0) begin
            mismatched++;
            $display("FAIL unsupported got fin=%b vld=%b want 1 0", fin0, vld0);
        end
        substate = 5'd2;
        tick();
        compared++;
        if (fin0 !== 1'b0 || vld0 !== 1'b0) begin
            mismatched++;
            $display("FAIL start_in_done got fin=%b vld=%b want 0 0", fin0, vld0);
        end
        tick();
        start = 1'b0;
        compared++;
        if (vld0 !== 1'b1 || cnt0 !== 11'd0) begin
            mismatched++;
            $display("FAIL earliest_start got vld=%b cnt=%0d want 1 0", vld0, cnt0);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_send();
        int finishTick;
        gen = 3'd1; substate = 5'd5; numberOfDetectedLanes = 5'd4;
        linkNumber = 8'h01; rateId = 8'h02; txReady = 1'b1; rxFinish = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        compared++;
        if (cnt0 !== 11'd8 || vld0 !== 1'b1) begin
            mismatched++;
            $display("FAIL midsend_count got cnt=%0d vld=%b want 8 1", cnt0, vld0);
        end
        rxFinish = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rxFinish = 1'b0;
        compared++;
        if (os0 !== '0 || vld0 !== 1'b0 || fin0 !== 1'b0 || cnt0 !== 11'd0) begin
            mismatched++;
            $display("FAIL midsend_reset got vld=%b fin=%b cnt=%0d osZero=%b want 0 0 0 1", vld0, fin0, cnt0, os0 == '0);
        end
        tick();
        compared++;
        if (fin0 !== 1'b0 || vld0 !== 1'b0) begin
            mismatched++;
            $display("FAIL midsend_no_finish got fin=%b vld=%b want 0 0", fin0, vld0);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        finishTick = -1;
        for (int t = 1; t <= 40; t++) begin
            if (fin0) begin
                finishTick = t;
                break;
            end
            rxFinish = (t == 1);
            tick();
        end
        rxFinish = 1'b0;
        compared++;
        if (finishTick != 17 || cnt0 !== 11'd16) begin
            mismatched++;
            $display("FAIL restart_count got finishTick=%0d cnt=%0d want 17 16", finishTick, cnt0);
        end
        tick();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; substate = 5'd0; gen = 3'd1;
        numberOfDetectedLanes = 5'd1; linkNumber = 8'h00; rateId = 8'h00;
        rxFinish = 1'b0; txReady = 1'b0;
        test_reset();
        test_ts2_gen1();
        test_polling_gen3();
        test_link_width();
        test_stall();
        test_back_to_back();
        test_reset_mid_send();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
